// File: rtl/uart_core.sv
// uart_core: full-duplex UART with a programmable baud divisor and one FIFO
// per direction.
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   wr_uart   push w_data into the TX FIFO
//   w_data    byte to transmit
//   tx_full   TX FIFO full (registered)
//   rd_uart   pop the RX FIFO head
//   r_data    RX FIFO head (first-word fall-through)
//   rx_empty  RX FIFO empty (registered)
//   dvsr      baud divisor, tick period is dvsr+1 clocks, 16 ticks per bit
//   tx        serial out, idle high
//   rx        serial in, idle high, asynchronous to clk

// uart_fifo: circular buffer with registered full/empty flags.
//   wr_i/w_data_i  push, rd_i pop, r_data_o head entry, full_o/empty_o status
module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [W-1:0] w_data_i,
  output logic [W-1:0] r_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q, wp_inc, rp_inc;
  logic          full_q, empty_q, do_wr, do_rd;

  assign wp_inc = wp_q + 1'b1;
  assign rp_inc = rp_q + 1'b1;
  // A write while full still lands when a pop frees the slot in the same cycle.
  assign do_wr  = wr_i & (~full_q | rd_i);
  assign do_rd  = rd_i & ~empty_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) begin
        mem_q[wp_q] <= w_data_i;
        wp_q        <= wp_inc;
      end
      if (do_rd) rp_q <= rp_inc;
      case ({do_wr, do_rd})
        2'b10: begin
          empty_q <= 1'b0;
          full_q  <= (wp_inc == rp_q);
        end
        2'b01: begin
          full_q  <= 1'b0;
          empty_q <= (rp_inc == wp_q);
        end
        default: ;
      endcase
    end
  end

  assign r_data_o = mem_q[rp_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
endmodule

module uart_core #(
  parameter int DBIT_WIDTH      = 8,
  parameter int SB_TICK         = 16,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_uart,
  input  logic                  wr_uart,
  input  logic [DBIT_WIDTH-1:0] w_data,
  output logic [DBIT_WIDTH-1:0] r_data,
  output logic                  tx_full,
  output logic                  rx_empty,
  input  logic [15:0]           dvsr,
  output logic                  tx,
  input  logic                  rx
);
  localparam int NW = $clog2(DBIT_WIDTH);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT_WIDTH - 1);
  localparam logic [5:0]    SB_LAST = 6'(SB_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Baud generator; the divisor is sampled at each wrap so a change only
  // affects the following period.
  logic [15:0] cnt_q, lim_q;
  logic        tick;

  assign tick = (cnt_q == lim_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      lim_q <= dvsr;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Transmitter
  state_t                tx_st_q;
  logic [5:0]            tx_s_q;
  logic [NW-1:0]         tx_n_q;
  logic [DBIT_WIDTH-1:0] tx_b_q, tx_head;
  logic                  tx_q, tx_done_q, tx_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q   <= IDLE;
      tx_s_q    <= '0;
      tx_n_q    <= '0;
      tx_b_q    <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_st_q)
        // The finished byte is still at the FIFO head while tx_done pops it.
        IDLE: if (!tx_empty && !tx_done_q) begin
          tx_st_q <= START;
          tx_b_q  <= tx_head;
          tx_s_q  <= 6'd16;
        end
        // Count 16 marks the wait for a tick boundary so the start bit is
        // exactly 16 tick periods long.
        START: if (tick) begin
          if (tx_s_q == 6'd16) begin
            tx_q   <= 1'b0;
            tx_s_q <= 6'd15;
          end else if (tx_s_q == '0) begin
            tx_st_q <= DATA;
            tx_q    <= tx_b_q[0];
            tx_s_q  <= 6'd15;
            tx_n_q  <= N_LAST;
          end else begin
            tx_s_q <= tx_s_q - 1'b1;
          end
        end
        DATA: if (tick) begin
          if (tx_s_q == '0) begin
            tx_b_q <= tx_b_q >> 1;
            if (tx_n_q == '0) begin
              tx_st_q <= STOP;
              tx_q    <= 1'b1;
              tx_s_q  <= SB_LAST;
            end else begin
              tx_n_q <= tx_n_q - 1'b1;
              tx_q   <= tx_b_q[1];
              tx_s_q <= 6'd15;
            end
          end else begin
            tx_s_q <= tx_s_q - 1'b1;
          end
        end
        STOP: if (tick) begin
          if (tx_s_q == '0) begin
            tx_st_q   <= IDLE;
            tx_done_q <= 1'b1;
          end else begin
            tx_s_q <= tx_s_q - 1'b1;
          end
        end
        default: tx_st_q <= IDLE;
      endcase
    end
  end

  assign tx = tx_q;

  // Receiver
  state_t                rx_st_q;
  logic [5:0]            rx_s_q;
  logic [NW-1:0]         rx_n_q;
  logic [DBIT_WIDTH-1:0] rx_b_q;
  logic                  rx_s1_q, rx_s2_q, rx_done_q, rx_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= IDLE;
      rx_s_q    <= '0;
      rx_n_q    <= '0;
      rx_b_q    <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_done_q <= 1'b0;
      case (rx_st_q)
        IDLE: if (!rx_s2_q) begin
          rx_st_q <= START;
          rx_s_q  <= 6'd7;
        end
        // Mid start bit: a high line here means the low was a glitch.
        START: if (tick) begin
          if (rx_s_q == '0) begin
            if (rx_s2_q) begin
              rx_st_q <= IDLE;
            end else begin
              rx_st_q <= DATA;
              rx_s_q  <= 6'd15;
              rx_n_q  <= N_LAST;
            end
          end else begin
            rx_s_q <= rx_s_q - 1'b1;
          end
        end
        DATA: if (tick) begin
          if (rx_s_q == '0) begin
            rx_b_q <= {rx_s2_q, rx_b_q[DBIT_WIDTH-1:1]};
            if (rx_n_q == '0) begin
              rx_st_q <= STOP;
              rx_s_q  <= SB_LAST;
            end else begin
              rx_n_q <= rx_n_q - 1'b1;
              rx_s_q <= 6'd15;
            end
          end else begin
            rx_s_q <= rx_s_q - 1'b1;
          end
        end
        STOP: if (tick) begin
          if (rx_s_q == '0) begin
            rx_st_q   <= IDLE;
            rx_done_q <= 1'b1;
          end else begin
            rx_s_q <= rx_s_q - 1'b1;
          end
        end
        default: rx_st_q <= IDLE;
      endcase
    end
  end

  uart_fifo #(.W(DBIT_WIDTH), .AW(FIFO_DEPTH_BITS)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (wr_uart),
    .rd_i     (tx_done_q),
    .w_data_i (w_data),
    .r_data_o (tx_head),
    .full_o   (tx_full),
    .empty_o  (tx_empty)
  );

  // A byte that arrives with no room (and no pop alongside) is dropped.
  uart_fifo #(.W(DBIT_WIDTH), .AW(FIFO_DEPTH_BITS)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (rx_done_q & (~rx_full | rd_uart)),
    .rd_i     (rd_uart),
    .w_data_i (rx_b_q),
    .r_data_o (r_data),
    .full_o   (rx_full),
    .empty_o  (rx_empty)
  );
endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_uart, wr_uart;
  logic [7:0]  w_data, r_data;
  logic        tx_full, rx_empty;
  logic [15:0] dvsr;
  logic        tx, rx;
  logic        loop_en, rx_drv;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_core dut (
    .clk      (clk),
    .rst      (rst),
    .rd_uart  (rd_uart),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .r_data   (r_data),
    .tx_full  (tx_full),
    .rx_empty (rx_empty),
    .dvsr     (dvsr),
    .tx       (tx),
    .rx       (rx)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = i-th bit on the wire (start .. stop)
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] txb[4];
  logic [9:0] txf[4];
  logic [7:0] ovb[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    w_data  = d;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic pop_byte();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  // Waits for a falling tx, then samples each bit centre (64 clocks/bit at dvsr=3).
  task automatic capture_frame(output logic [9:0] bits, output int low_len, output bit ok);
    int n;
    bits    = '1;
    low_len = 0;
    ok      = 1'b0;
    n       = 0;
    while (tx === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) return;
    ok = 1'b1;
    for (int k = 1; k <= 608; k++) begin
      @(negedge clk);
      if (low_len == 0 && tx === 1'b1) low_len = k;
      if (k >= 32 && ((k - 32) % 64) == 0) bits[(k - 32) / 64] = tx;
    end
  endtask

  task automatic count_low(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) c++;
    end
  endtask

  task automatic wait_rx_ready(output bit ok);
    int n;
    n = 0;
    while (rx_empty === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (rx_empty === 1'b0);
  endtask

  task automatic send_rx(input logic [7:0] d);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (64) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] bits, b0;
    int         low_len, l0, cnt;
    bit         ok, ok0;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h99, 10'b1100110010};
    vecs[3] = '{8'h7E, 10'b1011111100};
    txb[0] = 8'h01; txf[0] = 10'b1000000010;
    txb[1] = 8'h80; txf[1] = 10'b1100000000;
    txb[2] = 8'hF0; txf[2] = 10'b1111100000;
    txb[3] = 8'h0F; txf[3] = 10'b1000011110;
    ovb[0] = 8'h11; ovb[1] = 8'h22; ovb[2] = 8'h83; ovb[3] = 8'h4C; ovb[4] = 8'hF0;

    rst = 1'b0; wr_uart = 1'b0; rd_uart = 1'b0; w_data = '0;
    dvsr = 16'd3; loop_en = 1'b0; rx_drv = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_tx_full", 32'(tx_full), 32'h0);
    check("rst_rx_empty", 32'(rx_empty), 32'h1);
    check("rst_r_data", 32'(r_data), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single TX frame
    write_byte(8'hA5);
    capture_frame(bits, low_len, ok);
    check("tx1_started", 32'(ok), 32'h1);
    check("tx1_frame", 32'(bits), 32'(10'b1101001010));
    check("tx1_start_len", 32'(low_len), 32'd64);
    count_low(700, cnt);
    check("tx1_drained", 32'(cnt), 32'h0);
    check("tx1_not_full", 32'(tx_full), 32'h0);

    // Loopback vectors
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write_byte(vecs[i].data);
      capture_frame(bits, low_len, ok);
      check("lb_started", 32'(ok), 32'h1);
      check("lb_frame", 32'(bits), 32'(vecs[i].frame));
      wait_rx_ready(ok);
      check("lb_rx_ready", 32'(ok), 32'h1);
      check("lb_r_data", 32'(r_data), 32'(vecs[i].data));
      pop_byte();
      check("lb_rx_empty_after_rd", 32'(rx_empty), 32'h1);
      repeat (60) @(negedge clk);
    end
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // TX full: 4 back-to-back writes, the first starts a frame
    fork
      capture_frame(b0, l0, ok0);
      begin
        for (int i = 0; i < 4; i++) begin
          w_data  = txb[i];
          wr_uart = 1'b1;
          @(negedge clk);
        end
        wr_uart = 1'b0;
        check("txf_full", 32'(tx_full), 32'h1);
        write_byte(8'hEE);
        check("txf_still_full", 32'(tx_full), 32'h1);
      end
    join
    check("txf_started0", 32'(ok0), 32'h1);
    check("txf_frame0", 32'(b0), 32'(txf[0]));
    for (int i = 1; i < 4; i++) begin
      capture_frame(bits, low_len, ok);
      check("txf_started", 32'(ok), 32'h1);
      check("txf_frame", 32'(bits), 32'(txf[i]));
    end
    count_low(800, cnt);
    check("txf_fifth_dropped", 32'(cnt), 32'h0);
    check("txf_not_full", 32'(tx_full), 32'h0);

    // Glitch rejection
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (700) @(negedge clk);
    check("glitch_rx_empty", 32'(rx_empty), 32'h1);

    // RX overflow: 5 frames, no reads
    for (int i = 0; i < 5; i++) send_rx(ovb[i]);
    repeat (40) @(negedge clk);
    check("ovf_rx_not_empty", 32'(rx_empty), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_r_data", 32'(r_data), 32'(ovb[i]));
      pop_byte();
    end
    check("ovf_empty_after_4", 32'(rx_empty), 32'h1);

    // Asynchronous reset mid-frame
    send_rx(8'h5A);
    repeat (40) @(negedge clk);
    check("pre_rst_rx_ready", 32'(rx_empty), 32'h0);
    check("pre_rst_r_data", 32'(r_data), 32'h5A);
    for (int i = 0; i < 4; i++) begin
      w_data  = txb[i];
      wr_uart = 1'b1;
      @(negedge clk);
    end
    wr_uart = 1'b0;
    check("pre_rst_tx_full", 32'(tx_full), 32'h1);
    cnt = 0;
    while (tx === 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("pre_rst_tx_low", 32'(tx), 32'h0);
    rst = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'h1);
    check("async_rst_tx_full", 32'(tx_full), 32'h0);
    check("async_rst_rx_empty", 32'(rx_empty), 32'h1);
    check("async_rst_r_data", 32'(r_data), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    count_low(700, cnt);
    check("post_rst_tx_idle", 32'(cnt), 32'h0);
    check("post_rst_rx_empty", 32'(rx_empty), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/uart_core.md
# uart_core

Full-duplex UART with a programmable baud divisor and one FIFO per direction. The CPU-side write port queues bytes for serial transmission on `tx`. Bytes received on `rx` are queued for the CPU-side read port. The block sits between a register/bus interface and the board's serial pins.

## Interface
- `DBIT_WIDTH`, default 8: data bits per frame.
- `SB_TICK`, default 16: stop-bit length in baud ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `FIFO_DEPTH_BITS`, default 2: log2 of each FIFO's depth (default 4 entries).

Ports:
- `clk` input 1: system clock, all logic on the rising edge.
- `rst` input 1: reset. **Asynchronous, active-low.**
- `rd_uart` input 1: pops one entry from the RX FIFO.
- `wr_uart` input 1: pushes `w_data` into the TX FIFO.
- `w_data` input DBIT_WIDTH: byte to transmit.
- `r_data` output DBIT_WIDTH: head entry of the RX FIFO.
- `tx_full` output 1: TX FIFO full.
- `rx_empty` output 1: RX FIFO empty.
- `dvsr` input 16: baud divisor.
- `tx` output 1: serial out, idle high.
- `rx` input 1: serial in, idle high, asynchronous to `clk`.

## Operation
- **Baud generator.**
  - A 16-bit counter counts 0..`dvsr` and then wraps to 0.
  - A one-cycle `tick` fires when the counter equals `dvsr`, so the tick period is `dvsr`+1 clocks.
  - There are 16 ticks per bit (16x oversampling).
  - A change to `dvsr` takes effect at the next wrap.
- **Transmitter** states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. Moves to START when the TX FIFO is not empty, latching the head byte.
  - START: `tx`=0 for 16 ticks.
  - DATA: shifts out `DBIT_WIDTH` bits LSB first, 16 ticks each.
  - STOP: `tx`=1 for `SB_TICK` ticks, then pulses `tx_done` and returns to IDLE.
  - `tx_done` pops the TX FIFO. The byte occupies its FIFO slot for the entire frame.
- **Receiver** states: IDLE, START, DATA, STOP.
  - `rx` passes through a 2-flop synchronizer first.
  - IDLE: waits for the synchronized `rx` to read 0.
  - START: counts 8 ticks to reach the middle of the start bit. If `rx` is 1 there, the start is treated as a glitch and the receiver returns to IDLE. Otherwise it moves to DATA.
  - DATA: samples every 16 ticks (bit centres), shifting right so that bit 0 is received first, for `DBIT_WIDTH` bits.
  - STOP: waits `SB_TICK` ticks, then pulses `rx_done` and returns to IDLE.
  - `rx_done` pushes the byte into the RX FIFO. The stop-bit value is not checked.
- **FIFOs.** Circular buffers with 2^`FIFO_DEPTH_BITS` entries and wrapping read/write pointers.
  - `r_data` always shows the entry at the read pointer (first-word fall-through).
  - A write while full is ignored. For the RX side, the received byte is dropped.
  - A read while empty is ignored.
  - Simultaneous read and write:
    - Not full and not empty: both occur and the occupancy is unchanged.
    - Empty: only the write occurs.
    - Full: both occur.
- **Reset** (`rst`=0, asynchronous):
  - Both FSMs go to IDLE and the baud counter is cleared.
  - FIFO pointers and storage are cleared.
  - Outputs: `tx`=1, `tx_full`=0, `rx_empty`=1, `r_data`=0.
  - Reset mid-frame abandons the frame. `tx` goes high immediately and any partial RX byte is discarded.

## Timing
- `wr_uart` and `rd_uart` are sampled on `clk` rising edges. Each cycle held high counts as one push or pop. The CPU must gate writes on `tx_full` and reads on `rx_empty`.
- After a write to an empty TX FIFO, `rx_empty`-style status (`tx_full`) updates on the following edge. The TX FSM leaves IDLE on the clock after the FIFO becomes non-empty, and `tx` falls within one tick period after that.
- Frame length is (16·(1+`DBIT_WIDTH`)+`SB_TICK`)·(`dvsr`+1) clocks; for defaults, 160·(`dvsr`+1).
- `rx_done` occurs `SB_TICK` ticks after the last data sample. `rx_empty` deasserts on the next clock.
- `tx_full` and `rx_empty` are registered and change on the edge after the push or pop.
- Back-to-back frames: the next TX frame begins on the clock after `tx_done` if the FIFO is still non-empty.

## Test plan
- **Reset:** drive `rst`=0 mid-operation. Required: `tx`=1, `tx_full`=0, `rx_empty`=1, `r_data`=0 immediately, without waiting for a clock edge.
- **Single TX frame:** `dvsr`=3, write 0xA5. Required: on `tx`, start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each bit 64 clocks. The TX FIFO is empty after the frame.
- **Loopback:** tie `tx` to `rx` and write 0xA5, 0x3C, 0x99, 0x7E with one frame per write. Required: after each frame `rx_empty`=0 and `r_data` equals the byte written; `rd_uart` then restores `rx_empty`=1.
- **TX full:** with a frame in progress, write 4 consecutive bytes. Required: `tx_full`=1 after the 4th write. A 5th write is ignored, and the 4 bytes transmit in order.
- **RX overflow:** drive 5 frames into `rx` with no reads. Required: the first 4 bytes are retained in order and the 5th is dropped.
- **Glitch rejection:** a low pulse on `rx` shorter than 8 ticks. Required: no byte is received and `rx_empty` stays 1.
